// File: rtl/sdram_ctrl_pkg.sv
// Shared state encodings and small helpers for the SDRAM sequencing controller.
// Init and work state values are fixed because the command block decodes them.
package sdram_ctrl_pkg;

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_state_t;

  localparam int unsigned CNT_W = 10;

  // cnt_clk value on the final cycle of an n-cycle state
  function automatic logic [CNT_W-1:0] last_cycle(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  // cnt + slack <= burst, widened so small bursts cannot wrap the compare
  function automatic logic within_burst(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] burst,
                                        input int unsigned slack);
    return ({1'b0, cnt} + (CNT_W + 1)'(slack)) <= {1'b0, burst};
  endfunction

endpackage

// File: rtl/sdram_ctrl_ref_timer.sv
// Auto-refresh interval timer: free-runs once init is done and raises ref_req
// every TREF cycles; ref_req holds until the work FSM takes the refresh.
module sdram_ctrl_ref_timer #(
  parameter int unsigned TREF = 781
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ref_req
);

  localparam int unsigned TW = $clog2(TREF);

  logic [TW-1:0] tcnt;
  logic          wrap;

  assign wrap = en && (tcnt == TW'(TREF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      ref_req <= 1'b0;
    end else begin
      if (wrap)
        tcnt <= '0;
      else if (en)
        tcnt <= tcnt + TW'(1);
      // a new expiry outranks a clear so no refresh period is lost
      if (wrap)
        ref_req <= 1'b1;
      else if (clr)
        ref_req <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_ctrl.sv
// SDRAM sequencing FSM: power-up init, then refresh/write/read arbitration.
// Drives state and per-state cycle count to the command block and data acks to the user side.
module sdram_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned T200US  = 20000,
  parameter int unsigned TRP     = 3,
  parameter int unsigned TRFC    = 7,
  parameter int unsigned TRSC    = 3,
  parameter int unsigned TRCD    = 2,
  parameter int unsigned TCL     = 3,
  parameter int unsigned TWR     = 2,
  parameter int unsigned TREF    = 781,
  parameter int unsigned INIT_AR = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic       sdram_init_done,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr
);

  localparam int unsigned PW = $clog2(T200US);
  localparam int unsigned AW = $clog2(INIT_AR + 1);

  init_state_t   init_q, init_d;
  work_state_t   work_q, work_d;
  logic          rd_wr_q, rd_wr_d;
  logic [PW-1:0] pwr_cnt;
  logic [AW-1:0] ar_cnt;
  logic          ref_req, ref_clr;

  sdram_ctrl_ref_timer #(.TREF(TREF)) u_ref_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (init_q == I_DONE),
    .clr     (ref_clr),
    .ref_req (ref_req)
  );

  always_comb begin
    init_d = init_q;
    case (init_q)
      I_NOP:   if (pwr_cnt == PW'(T200US - 1)) init_d = I_PRE;
      I_PRE:   init_d = I_TRP;
      I_TRP:   if (cnt_clk == last_cycle(TRP)) init_d = I_AR;
      I_AR:    init_d = I_TRF;
      I_TRF:   if (cnt_clk == last_cycle(TRFC))
                 init_d = (ar_cnt == AW'(INIT_AR)) ? I_MRS : I_AR;
      I_MRS:   init_d = I_TRSC;
      I_TRSC:  if (cnt_clk == last_cycle(TRSC)) init_d = I_DONE;
      I_DONE:  init_d = I_DONE;
      default: init_d = I_NOP;
    endcase
  end

  // Requests are levels held by the requester until it sees its ack; they are
  // only looked at in W_IDLE, and each ack is high once per data word.
  always_comb begin
    work_d  = work_q;
    rd_wr_d = rd_wr_q;
    ref_clr = 1'b0;
    case (work_q)
      W_IDLE: if (init_q == I_DONE) begin
        if (ref_req) begin
          work_d  = W_AR;
          ref_clr = 1'b1;
        end else if (sdram_wr_req) begin
          work_d  = W_ACTIVE;
          rd_wr_d = 1'b0;
        end else if (sdram_rd_req) begin
          work_d  = W_ACTIVE;
          rd_wr_d = 1'b1;
        end
      end
      W_ACTIVE: work_d = W_TRCD;
      W_TRCD:   if (cnt_clk == last_cycle(TRCD)) work_d = rd_wr_q ? W_READ : W_WRITE;
      W_READ:   work_d = W_CL;
      W_CL:     if (cnt_clk == last_cycle(TCL - 1)) work_d = W_RD;
      W_RD:     if (cnt_clk == sdram_rd_burst - 10'd1) work_d = W_PRE;
      W_WRITE:  work_d = W_WD;
      W_WD:     if (cnt_clk == sdram_wr_burst - 10'd1) work_d = W_TWR;
      W_TWR:    if (cnt_clk == last_cycle(TWR)) work_d = W_PRE;
      W_PRE:    work_d = W_TRP;
      W_TRP:    if (cnt_clk == last_cycle(TRP)) work_d = W_IDLE;
      W_AR:     work_d = W_TRFC;
      W_TRFC:   if (cnt_clk == last_cycle(TRFC)) work_d = W_IDLE;
      default:  work_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= I_NOP;
      work_q  <= W_IDLE;
      rd_wr_q <= 1'b0;
      cnt_clk <= '0;
      pwr_cnt <= '0;
      ar_cnt  <= '0;
    end else begin
      init_q  <= init_d;
      work_q  <= work_d;
      rd_wr_q <= rd_wr_d;
      cnt_clk <= ((init_d != init_q) || (work_d != work_q)) ? '0 : cnt_clk + 10'd1;
      if (init_q == I_NOP) pwr_cnt <= pwr_cnt + PW'(1);
      if (init_q == I_AR)  ar_cnt  <= ar_cnt + AW'(1);
    end
  end

  assign init_state      = init_q;
  assign work_state      = work_q;
  assign sdram_rd_wr     = rd_wr_q;
  assign sdram_init_done = (init_q == I_DONE);
  assign sdram_wr_ack    = (work_q == W_WRITE) ||
                           ((work_q == W_WD) && within_burst(cnt_clk, sdram_wr_burst, 2));
  assign sdram_rd_ack    = (work_q == W_RD) && within_burst(cnt_clk, sdram_rd_burst, 1);

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl: init timing, write/read bursts, arbitration,
// refresh deferral across a long burst, and asynchronous reset mid-read.
module tb_sdram_ctrl;
  import sdram_ctrl_pkg::*;

  localparam int INIT_CYCLES = 20000 + 1 + 3 + 8 * (1 + 7) + 1 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sdram_wr_req, sdram_rd_req;
  logic [9:0] sdram_wr_burst, sdram_rd_burst;
  logic       sdram_wr_ack, sdram_rd_ack, sdram_init_done, sdram_rd_wr;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [3:0] st_q[$];
  int         len_q[$];
  logic [3:0] exp_q[$];
  int         exp_len_q[$];
  int         wr_ack_n, rd_ack_n, first_ack, last_ack;
  logic [3:0] ack_state;
  logic       rdwr_start, trace_ok;

  sdram_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_rd_burst  (sdram_rd_burst),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_init_done (sdram_init_done),
    .init_state      (init_state),
    .work_state      (work_state),
    .cnt_clk         (cnt_clk),
    .sdram_rd_wr     (sdram_rd_wr)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_init_state"}, init_state, I_NOP);
    check({tag, "_work_state"}, work_state, W_IDLE);
    check({tag, "_cnt_clk"}, cnt_clk, 0);
    check({tag, "_rd_wr"}, sdram_rd_wr, 0);
    check({tag, "_acks"}, {sdram_wr_ack, sdram_rd_ack}, 0);
    check({tag, "_init_done"}, sdram_init_done, 0);
  endtask

  task automatic wait_init(input string tag);
    int cycles, ar_visits;
    logic [4:0] prev;
    cycles = 0;
    ar_visits = 0;
    prev = init_state;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (init_state == I_AR && prev != I_AR) ar_visits++;
      prev = init_state;
    end while (!sdram_init_done && cycles < 25000);
    check({tag, "_done_cycle"}, cycles, INIT_CYCLES);
    check({tag, "_ar_visits"}, ar_visits, 8);
    check({tag, "_done_cnt_clk"}, cnt_clk, 0);
    check({tag, "_done_work_idle"}, work_state, W_IDLE);
  endtask

  // Record one excursion out of W_IDLE as run-length (state, cycles) pairs.
  task automatic trace_txn(input int budget);
    int n, idx;
    logic started, ended;
    st_q.delete();
    len_q.delete();
    wr_ack_n = 0; rd_ack_n = 0; first_ack = -1; last_ack = -1;
    ack_state = 4'hf; rdwr_start = 1'bx;
    started = 1'b0; ended = 1'b0; n = 0;
    while (!ended && n < budget) begin
      @(negedge clk);
      n++;
      if (work_state != W_IDLE) begin
        if (!started || work_state != st_q[st_q.size() - 1]) begin
          if (!started) rdwr_start = sdram_rd_wr;
          st_q.push_back(work_state);
          len_q.push_back(1);
        end else begin
          idx = len_q.size() - 1;
          len_q[idx] = len_q[idx] + 1;
        end
        started = 1'b1;
      end else if (started) begin
        ended = 1'b1;
      end
      if (sdram_wr_ack || sdram_rd_ack) begin
        if (first_ack < 0) begin
          first_ack = n;
          ack_state = work_state;
        end
        last_ack = n;
      end
      if (sdram_wr_ack) begin wr_ack_n++; sdram_wr_req = 1'b0; end
      if (sdram_rd_ack) begin rd_ack_n++; sdram_rd_req = 1'b0; end
    end
    trace_ok = ended;
  endtask

  task automatic compare_seq(input string name);
    check({name, "_finished"}, trace_ok, 1);
    check({name, "_nstates"}, st_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < st_q.size(); i++) begin
      check($sformatf("%s_state%0d", name, i), st_q[i], exp_q[i]);
      check($sformatf("%s_cycles%0d", name, i), len_q[i], exp_len_q[i]);
    end
  endtask

  task automatic check_acks(input string name, input int wr_n, input int rd_n,
                            input logic [3:0] first_state, input logic rdwr);
    check({name, "_wr_ack_cycles"}, wr_ack_n, wr_n);
    check({name, "_rd_ack_cycles"}, rd_ack_n, rd_n);
    check({name, "_ack_contiguous"}, last_ack - first_ack + 1, wr_n + rd_n);
    check({name, "_first_ack_state"}, ack_state, first_state);
    check({name, "_rd_wr"}, rdwr_start, rdwr);
  endtask

  initial begin
    int t0, n;
    sdram_wr_req = 1'b0;
    sdram_rd_req = 1'b0;
    sdram_wr_burst = 10'd16;
    sdram_rd_burst = 10'd8;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_init("init1");
    t0 = cyc;

    // write, burst 16
    sdram_wr_burst = 10'd16;
    sdram_wr_req = 1'b1;
    trace_txn(200);
    exp_q = '{W_ACTIVE, W_TRCD, W_WRITE, W_WD, W_TWR, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 16, 2, 1, 3};
    compare_seq("wr16");
    check_acks("wr16", 16, 0, W_WRITE, 1'b0);

    // read, burst 8
    sdram_rd_burst = 10'd8;
    sdram_rd_req = 1'b1;
    trace_txn(200);
    exp_q = '{W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 2, 8, 1, 3};
    compare_seq("rd8");
    check_acks("rd8", 0, 8, W_RD, 1'b1);

    // simultaneous requests with minimum bursts: write first, then read
    sdram_wr_burst = 10'd1;
    sdram_rd_burst = 10'd4;
    sdram_wr_req = 1'b1;
    sdram_rd_req = 1'b1;
    trace_txn(200);
    exp_q = '{W_ACTIVE, W_TRCD, W_WRITE, W_WD, W_TWR, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 1, 2, 1, 3};
    compare_seq("both_wr1");
    check_acks("both_wr1", 1, 0, W_WRITE, 1'b0);
    trace_txn(200);
    exp_q = '{W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 2, 4, 1, 3};
    compare_seq("both_rd4");
    check_acks("both_rd4", 0, 4, W_RD, 1'b1);

    // 512-word write straddling the refresh expiry, with a read pending
    while (cyc - t0 < 400) @(negedge clk);
    sdram_wr_burst = 10'd512;
    sdram_rd_burst = 10'd8;
    sdram_wr_req = 1'b1;
    sdram_rd_req = 1'b1;
    trace_txn(1000);
    exp_q = '{W_ACTIVE, W_TRCD, W_WRITE, W_WD, W_TWR, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 512, 2, 1, 3};
    compare_seq("wr512");
    check_acks("wr512", 512, 0, W_WRITE, 1'b0);
    trace_txn(200);
    exp_q = '{W_AR, W_TRFC};
    exp_len_q = '{1, 7};
    compare_seq("refresh");
    check("refresh_rd_wr_held", sdram_rd_wr, 0);
    trace_txn(200);
    exp_q = '{W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 2, 8, 1, 3};
    compare_seq("rd_after_ref");
    check_acks("rd_after_ref", 0, 8, W_RD, 1'b1);

    // asynchronous reset in the middle of a read burst
    sdram_rd_burst = 10'd8;
    sdram_rd_req = 1'b1;
    n = 0;
    while (work_state != W_RD && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_rd_reached", work_state, W_RD);
    check("mid_rd_ack", sdram_rd_ack, 1);
    check("mid_rd_rd_wr", sdram_rd_wr, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rd_reset");
    sdram_rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");

    // first transaction after re-init must not be preceded by a refresh
    sdram_wr_burst = 10'd1;
    sdram_wr_req = 1'b1;
    trace_txn(200);
    exp_q = '{W_ACTIVE, W_TRCD, W_WRITE, W_WD, W_TWR, W_PRE, W_TRP};
    exp_len_q = '{1, 2, 1, 1, 2, 1, 3};
    compare_seq("post_reset_wr1");
    check_acks("post_reset_wr1", 1, 0, W_WRITE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
